cell_bist_ctrl: RTL and testbench



---
 rtl/cell_bist_pkg.sv | 17 +
 rtl/cell_bist_vecgen.sv | 18 +
 rtl/cell_bist_ctrl.sv | 151 +++++++++++++++
 tb/tb_cell_bist_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_bist_pkg.sv
// Shared types and truth-table constants for the standard-cell BIST sequencer.
package cell_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } cell_bist_state_t;

    localparam logic [7:0] OAI21_TRUTH = 8'h1F;
    localparam logic [7:0] AOI21_TRUTH = 8'h07;
    localparam logic [3:0] NAND2_TRUTH = 4'h7;
    localparam logic [3:0] NOR2_TRUTH  = 4'h1;

endpackage

// File: rtl/cell_bist_vecgen.sv
// Vector index to cell-input mapping; binary order by default, Gray order
// (one input toggles per step) when CELL_BIST_GRAY_EN is defined.
module cell_bist_vecgen
    import cell_bist_pkg::*;
#(
    parameter int unsigned N_IN = 3
) (
    input  logic [N_IN-1:0] idx_i,
    output logic [N_IN-1:0] vec_c
);

`ifdef CELL_BIST_GRAY_EN
    assign vec_c = idx_i ^ (idx_i >> 1);
`else
    assign vec_c = idx_i;
`endif

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST sequencer: walks a combinational cell through every input vector and
// checks Y against a truth table. Vector order set by CELL_BIST_GRAY_EN.
module cell_bist_ctrl
    import cell_bist_pkg::*;
#(
    parameter int unsigned          N_IN       = 3,
    parameter int unsigned          SETTLE_CYC = 4,
    parameter logic [(2**N_IN)-1:0] EXPECT     = OAI21_TRUTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_y,
    output logic [N_IN-1:0] drive,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int unsigned CNT_W = N_IN + 1;
    localparam int unsigned SET_W = 8;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        (SETTLE_CYC == 0) ? '0 : SET_W'(SETTLE_CYC - 1);

    cell_bist_state_t  state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [N_IN-1:0]   drive_q, drive_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;
    logic [N_IN-1:0]   vec_c;

    cell_bist_vecgen #(
        .N_IN (N_IN)
    ) u_vecgen (
        .idx_i (idx_q),
        .vec_c (vec_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            ffv_q      <= '0;
            ffvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffvalid_q  <= ffvalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        drive_d    = drive_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffvalid_d  = ffvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_APPLY;
                    idx_d      = '0;
                    fail_cnt_d = '0;
                    ffv_d      = '0;
                    ffvalid_d  = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            ST_APPLY: begin
                drive_d  = vec_c;
                settle_d = SETTLE_LOAD;
                state_d  = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (dut_y != EXPECT[drive_q]) begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                    if (!ffvalid_q) begin
                        ffv_d     = drive_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (&idx_q) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = ST_APPLY;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                pass_d  = (fail_cnt_q == '0);
                drive_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the done pulse in FINISH.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            drive_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign drive            = drive_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_cnt         = fail_cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Scoreboard bench for cell_bist_ctrl: OAI21 cell model with injectable faults.
module tb_cell_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic       dut_y;
    logic [2:0] drive;
    logic       busy, done, pass;
    logic [3:0] fail_cnt;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;

    logic       start0, abort0;
    logic       dut_y0;
    logic [2:0] drive0;
    logic       busy0, done0, pass0;
    logic [3:0] fail_cnt0;
    logic [2:0] ffv0;
    logic       ffvalid0;

    int         mode;
    int         cyc;
    int         n_checks;
    int         n_pass;
    logic [2:0] exp_order [8];

    typedef struct {
        bit pass;
        int fcnt;
        int ffv;
        bit ffvalid;
        int t0;
    } exp_t;

    exp_t sb[$];

    cell_bist_ctrl u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .dut_y            (dut_y),
        .drive            (drive),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_cnt         (fail_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    cell_bist_ctrl #(.SETTLE_CYC(0)) u_dut0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start0),
        .abort            (abort0),
        .dut_y            (dut_y0),
        .drive            (drive0),
        .busy             (busy0),
        .done             (done0),
        .pass             (pass0),
        .fail_cnt         (fail_cnt0),
        .first_fail_vec   (ffv0),
        .first_fail_valid (ffvalid0)
    );

    // Ideal OAI21: Y = ~((A|B)&C); mode 1 = stuck-at-0, mode 2 = flipped at drive 6.
    function automatic logic cell_y(input logic [2:0] d, input int m);
        logic y;
        y = ~((d[0] | d[1]) & d[2]);
        if (m == 1) y = 1'b0;
        if (m == 2 && d == 3'd6) y = ~y;
        return y;
    endfunction

    always_comb dut_y  = cell_y(drive, mode);
    always_comb dut_y0 = cell_y(drive0, 0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done pulse with no run outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("run_latency", cyc - e.t0, 49);
                chk("run_pass", int'(pass), int'(e.pass));
                chk("run_fail_cnt", int'(fail_cnt), e.fcnt);
                chk("run_first_fail_vec", int'(first_fail_vec), e.ffv);
                chk("run_first_fail_valid", int'(first_fail_valid), int'(e.ffvalid));
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller is positioned just after a negedge (or at a negedge).
    task automatic start_run(input bit push, input bit p, input int fc, input int fv,
                             input bit fvv, output int t0);
        exp_t e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        if (push) begin
            e.pass = p; e.fcnt = fc; e.ffv = fv; e.ffvalid = fvv; e.t0 = t0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_drive"}, int'(drive), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
        chk({tag, "_ffv"}, int'(first_fail_vec), 0);
        chk({tag, "_ffvalid"}, int'(first_fail_valid), 0);
    endtask

    initial begin
        int t0;
        bit seen0;
        n_checks = 0;
        n_pass   = 0;
        mode     = 0;
        start    = 1'b0;
        abort    = 1'b0;
        start0   = 1'b0;
        abort0   = 1'b0;
        rst_n    = 1'b0;
`ifdef CELL_BIST_GRAY_EN
        exp_order = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        exp_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal run with a spurious start mid-run (must be ignored).
        mode = 0;
        start_run(1'b1, 1'b1, 0, 0, 1'b0, t0);
        chk("busy_in_run", int'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            wait_cyc(t0 + 6 * k + 1);
            chk($sformatf("drive_order_%0d", k), int'(drive), int'(exp_order[k]));
            if (k == 1) begin
                @(negedge clk);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        wait_done("ideal_done", 60);
        chk("busy_at_done", int'(busy), 0);
        chk("drive_at_done", int'(drive), 0);

        // Stuck-at-0 output: vectors 0..4 expect 1.
        repeat (3) @(negedge clk);
        mode = 1;
        start_run(1'b1, 1'b0, 5, 0, 1'b1, t0);
        wait_done("stuck0_done", 60);

        // Single flipped vector, then a back-to-back clean run.
        repeat (2) @(negedge clk);
        mode = 2;
        start_run(1'b1, 1'b0, 1, 6, 1'b1, t0);
        wait_done("flip6_done", 60);
        mode = 0;
        start_run(1'b1, 1'b1, 0, 0, 1'b0, t0);
        chk("b2b_accept_busy", int'(busy), 1);
        wait_done("b2b_done", 60);

        // Abort at cycle 20 keeps partial results, no done pulse.
        repeat (2) @(negedge clk);
        mode = 1;
        start_run(1'b0, 1'b0, 0, 0, 1'b0, t0);
        wait_cyc(t0 + 20);
        chk("abort_pre_drive", int'(drive), int'(exp_order[3]));
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_drive", int'(drive), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_fail_cnt", int'(fail_cnt), 3);
        chk("abort_ffv", int'(first_fail_vec), 0);
        chk("abort_ffvalid", int'(first_fail_valid), 1);
        repeat (60) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);

        // start together with abort in IDLE: stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("start_abort_busy", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        chk("start_abort_busy2", int'(busy), 0);

        // Asynchronous reset mid-run, then a full clean run.
        @(negedge clk);
        mode = 1;
        start_run(1'b0, 1'b0, 0, 0, 1'b0, t0);
        wait_cyc(t0 + 24);
        chk("prereset_fail_cnt", int'(fail_cnt), 4);
        wait_cyc(t0 + 30);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 0;
        start_run(1'b1, 1'b1, 0, 0, 1'b0, t0);
        wait_done("post_reset_done", 60);

        // Zero-settle instance: 2 cycles per vector.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            wait_cyc(t0 + 2 * k + 1);
            chk($sformatf("s0_drive_order_%0d", k), int'(drive0), int'(exp_order[k]));
        end
        seen0 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done0) begin
                seen0 = 1'b1;
                break;
            end
        end
        if (!seen0) begin
            n_checks++;
            $display("FAIL s0_done: done not seen within 40 cycles");
        end else begin
            chk("s0_latency", cyc - t0, 17);
            chk("s0_pass", int'(pass0), 1);
            chk("s0_fail_cnt", int'(fail_cnt0), 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
